// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants for the instruction fetch stage:
//   FETCH_DEPTH : buffer entries, and the maximum of (outstanding + buffered)
//   CNT_W/cnt_t : counter type able to hold 0..FETCH_DEPTH
//   RV_NOP      : canonical RISC-V NOP (addi x0, x0, 0) shown on faulted entries
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t        DEPTH_CNT = cnt_t'(FETCH_DEPTH);
    localparam logic [31:0] RV_NOP    = 32'h0000_0013;

    // A fetch target whose low two bits are not zero cannot be fetched as a word.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry in-order FIFO of packed fetch entries {inst, pc, err}.
// The head is always held in entry0_q, so head_o comes straight from a register.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_i/push_data_i : write one entry (ignored when flush_i is high)
//   pop_i          : remove the head
//   flush_i        : empty the queue; wins over push
//   full_o/empty_o/count_o : occupancy
//   head_o         : oldest entry (holds RESET_DATA out of reset)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int                DATA_W     = 65,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output cnt_t              count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] entry0_q;
    logic [DATA_W-1:0] entry1_q;
    cnt_t              count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = entry0_q;

    assign do_pop  = pop_i && !empty_o;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the two entries are reset (cheap at this size) so inst/inst_pc
            // show defined values while the queue is empty after reset.
            entry0_q <= RESET_DATA;
            entry1_q <= RESET_DATA;
            count_q  <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (empty_o) entry0_q <= push_data_i;
                    else         entry1_q <= push_data_i;
                    count_q <= count_q + cnt_t'(1);
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - cnt_t'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new entry lands behind whatever remains.
                    if (count_q == cnt_t'(1)) begin
                        entry0_q <= push_data_i;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers in-order responses and hands {inst, inst_pc, fetch_error} to
// decode. Redirects flush the buffer and discard in-flight (stale) responses.
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          : request channel (addr = pc_q)
//   imem_resp_valid/data/error         : in-order responses, no back-pressure
//   redirect_valid/target              : one-cycle PC change (highest priority)
//   inst_valid/ready, inst, inst_pc, fetch_error : decode handshake
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = FETCH_DEPTH  // queue is built for exactly 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_error,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_error
);

    localparam int              ENTRY_W     = 2 * XLEN + 1;
    localparam logic [XLEN-1:0] NOP         = XLEN'(RV_NOP);
    localparam logic [XLEN-1:0] WORD_BYTES  = XLEN'(4);
    localparam logic [ENTRY_W-1:0] RESET_ENTRY = {NOP, RESET_PC, 1'b0};

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;      // pc of the next non-stale response
    cnt_t               outstanding_q, outstanding_d;
    cnt_t               drop_cnt_q, drop_cnt_d;    // stale responses still to discard
    logic               halted_q, halted_d;
    logic               err_pending_q, err_pending_d;  // misaligned entry waits for the flush

    logic               q_push;
    logic [ENTRY_W-1:0] q_push_data;
    logic               q_full;
    logic               q_empty;
    cnt_t               q_count;
    logic [ENTRY_W-1:0] q_head;

    logic               pop;
    logic               req_fire;
    logic [2:0]         credit_used;

    assign pop = inst_valid && inst_ready;

    // Credits: everything in flight or buffered, minus the slot decode frees this
    // cycle. Using pop here is what sustains one instruction per cycle.
    assign credit_used = 3'(outstanding_q) + 3'(q_count) - 3'(pop);

    // Gated with reset_n so the request drops asynchronously with reset.
    assign imem_req_valid = reset_n && !halted_q && !redirect_valid
                            && (credit_used < 3'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // NOTE: blocking assignments in this combinational block; every signal gets
    // a default first, so no latch can be inferred on any path.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        halted_d      = halted_q;
        err_pending_d = 1'b0;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(imem_resp_valid);
        q_push        = 1'b0;
        q_push_data   = {NOP, resp_pc_q, 1'b1};

        if (imem_resp_valid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end else begin
                q_push      = 1'b1;
                q_push_data = {(imem_resp_error ? NOP : imem_resp_data),
                               resp_pc_q, imem_resp_error};
                resp_pc_d   = resp_pc_q + WORD_BYTES;
            end
        end

        // While this is pending every in-flight response is stale, so the
        // response path above never pushes in the same cycle.
        if (err_pending_q) begin
            q_push      = 1'b1;
            q_push_data = {NOP, resp_pc_q, 1'b1};
        end

        if (req_fire) begin
            pc_d = pc_q + WORD_BYTES;
        end

        if (redirect_valid) begin
            pc_d          = redirect_target;
            resp_pc_d     = redirect_target;
            // Whatever is still in flight after this cycle belongs to the old path.
            drop_cnt_d    = outstanding_d;
            halted_d      = is_misaligned(redirect_target[1:0]);
            err_pending_d = halted_d;
            q_push        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            halted_q      <= 1'b0;
            err_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
            err_pending_q <= err_pending_d;
        end
    end

    fetch_queue #(
        .DATA_W     (ENTRY_W),
        .RESET_DATA (RESET_ENTRY)
    ) u_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count),
        .head_o      (q_head)
    );

    assign inst_valid                   = !q_empty;
    assign {inst, inst_pc, fetch_error} = q_head;

    // Credit accounting must make a push into a full, non-popping queue impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(q_push && !redirect_valid && q_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (RESET_PC = 0) ----------------
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_error;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid, inst_ready, fetch_error;
    logic [31:0] inst, inst_pc;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_error(imem_resp_error),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .fetch_error(fetch_error)
    );

    // ---------------- wrap DUT (RESET_PC = FFFF_FFF8) ----------------
    logic        w_reset_n = 1'b0;
    logic        w_req_valid, w_inst_valid, w_fetch_error;
    logic        w_req_ready = 1'b1, w_inst_ready = 1'b1, w_redirect_valid = 1'b0;
    logic        w_resp_valid = 1'b0, w_resp_error = 1'b0;
    logic [31:0] w_req_addr, w_inst, w_inst_pc;
    logic [31:0] w_resp_data = 32'h0, w_redirect_target = 32'h0;

    fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset_n(w_reset_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .imem_resp_error(w_resp_error),
        .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst),
        .inst_pc(w_inst_pc), .fetch_error(w_fetch_error)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents and fault map, shared by the memory model and the reference.
    logic [31:0] err_addr = 32'h1;   // unaligned value: matches no fetch
    bit          rand_err = 1'b0;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0100_0000;
    endfunction

    function automatic logic err_fn(input logic [31:0] a);
        return (a == err_addr) || (rand_err && a[4:2] == 3'd5);
    endfunction

    // In-order memory: each accepted request answers at its due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];
    int    cyc, last_due, lat_min, lat_max;

    // Reference model: the architectural instruction stream decode must see.
    logic [31:0] exp_pc, exp_req_pc, mis_target;
    bit          mis_pending, halted_m;
    logic [31:0] cons_pc[$], cons_inst[$];
    logic        cons_err[$];
    bit          hold_valid;
    logic [31:0] hold_inst, hold_pc;
    logic        hold_err;

    task automatic do_reset();
        reset_n = 1'b0;
        inst_ready = 1'b0; imem_req_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; imem_resp_error = 1'b0;
        memq.delete(); last_due = -1; cyc = 0;
        exp_pc = 32'h0; exp_req_pc = 32'h0; mis_target = 32'h0;
        mis_pending = 1'b0; halted_m = 1'b0; hold_valid = 1'b0;
        cons_pc.delete(); cons_inst.delete(); cons_err.delete();
        repeat (2) @(posedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_fetch_error", fetch_error, 0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 32'h0);
        #2 reset_n = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, observe handshakes just after.
    task automatic cycle(input bit ir, input bit mr, input bit rv, input logic [31:0] rt);
        mreq_t       m;
        int          lat;
        int          due;
        logic        e;
        @(negedge clk);
        inst_ready = ir; imem_req_ready = mr;
        redirect_valid = rv; redirect_target = rt;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = data_fn(m.addr);
            imem_resp_error = err_fn(m.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            imem_resp_error = 1'($urandom_range(0, 1));
        end
        #1;
        if (hold_valid) begin
            check("hold_valid", inst_valid, 1);
            check("hold_inst", inst, hold_inst);
            check("hold_pc", inst_pc, hold_pc);
            check("hold_err", fetch_error, hold_err);
        end
        hold_valid = inst_valid && !ir && !rv;
        hold_inst = inst; hold_pc = inst_pc; hold_err = fetch_error;

        if (rv || halted_m) check("req_blocked", imem_req_valid, 0);
        if (imem_req_valid && mr) begin
            check("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: imem_req_addr, due: due});
        end

        if (inst_valid && ir) begin
            cons_pc.push_back(inst_pc); cons_inst.push_back(inst); cons_err.push_back(fetch_error);
            if (mis_pending) begin
                check("mis_pc", inst_pc, mis_target);
                check("mis_inst", inst, NOP);
                check("mis_err", fetch_error, 1);
                mis_pending = 1'b0;
            end else if (halted_m) begin
                check("halted_inst_valid", inst_valid, 0);
            end else begin
                e = err_fn(exp_pc);
                check("inst_pc", inst_pc, exp_pc);
                check("fetch_error", fetch_error, e);
                check("inst", inst, e ? NOP : data_fn(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end

        if (rv) begin
            exp_pc = rt; exp_req_pc = rt; mis_target = rt;
            mis_pending = (rt[1:0] != 2'b00);
            halted_m = mis_pending;
        end
        cyc++;
    endtask

    // Wrap DUT: always-ready memory with a fixed one-cycle latency.
    logic [31:0] w_pcs[$], w_data[$];
    logic        w_errs[$];

    task automatic w_cycles(input int n);
        bit          pend;
        logic [31:0] pa;
        pend = 1'b0; pa = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_resp_valid = pend; w_resp_data = data_fn(pa); w_resp_error = 1'b0;
            #1;
            pend = w_req_valid; pa = w_req_addr;
            if (w_inst_valid) begin
                w_pcs.push_back(w_inst_pc); w_data.push_back(w_inst); w_errs.push_back(w_fetch_error);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int idx2;
        logic [31:0] t;

        // 1: streaming, one instruction per cycle from the third cycle
        do_reset(); lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 32'h0);
            if (i == 0) check("t1_first_req", imem_req_valid, 1);
            if (i == 2) check("t1_pc_cycle2", inst_pc, 32'h0);
            if (i >= 2) check("t1_no_gap", inst_valid, 1);
        end
        check("t1_count", cons_pc.size(), 18);

        // 2: decode stall fills the buffer and throttles requests
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 32'h0);
            if (i >= 3) check("t2_req_drop", imem_req_valid, 0);
        end
        check("t2_head_valid", inst_valid, 1);
        check("t2_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 32'h0);
        check("t2_count", cons_pc.size(), 16);

        // 3: redirect with two stale requests in flight
        do_reset(); lat_min = 3; lat_max = 3;
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        check("t3_outstanding", memq.size(), 2);
        cycle(1, 1, 1, 32'h100);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 32'h0);
        if (cons_pc.size() >= 2) begin
            check("t3_first_pc", cons_pc[0], 32'h100);
            check("t3_second_pc", cons_pc[1], 32'h104);
        end else check("t3_count", cons_pc.size(), 2);

        // 4: misaligned redirect halts until the next redirect
        do_reset(); lat_min = 2; lat_max = 2;
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 1, 32'h102);
        idx = cons_pc.size();
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 32'h0);
        check("t4_single_entry", cons_pc.size(), idx + 1);
        if (cons_pc.size() > idx) begin
            check("t4_pc", cons_pc[idx], 32'h102);
            check("t4_err", cons_err[idx], 1);
            check("t4_inst", cons_inst[idx], NOP);
        end
        cycle(1, 1, 1, 32'h200);
        idx2 = cons_pc.size();
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 32'h0);
        if (cons_pc.size() > idx2 + 2) check("t4_resume_pc", cons_pc[idx2], 32'h200);
        else check("t4_resume_count", cons_pc.size(), idx2 + 3);

        // 5: access fault on 0x8, fetch continues sequentially
        do_reset(); lat_min = 1; lat_max = 1; err_addr = 32'h8;
        for (int i = 0; i < 14; i++) cycle(1, 1, 0, 32'h0);
        if (cons_pc.size() >= 4) begin
            check("t5_fault_pc", cons_pc[2], 32'h8);
            check("t5_fault_err", cons_err[2], 1);
            check("t5_fault_inst", cons_inst[2], NOP);
            check("t5_next_pc", cons_pc[3], 32'hC);
            check("t5_next_err", cons_err[3], 0);
        end else check("t5_count", cons_pc.size(), 4);
        err_addr = 32'h1;

        // 6: RESET_PC near the top of memory, wrap, async reset mid-stream
        check("t6_rst_pc", w_inst_pc, WRAP_PC);
        check("t6_rst_req", w_req_valid, 0);
        @(posedge clk); #2 w_reset_n = 1'b1;
        w_cycles(6);
        if (w_pcs.size() >= 3) begin
            check("t6_pc0", w_pcs[0], 32'hFFFF_FFF8);
            check("t6_pc1", w_pcs[1], 32'hFFFF_FFFC);
            check("t6_pc2", w_pcs[2], 32'h0000_0000);
            check("t6_data2", w_data[2], data_fn(32'h0));
            check("t6_err2", w_errs[2], 0);
        end else check("t6_count", w_pcs.size(), 3);
        #2;
        check("t6_pre_valid", w_inst_valid, 1);
        w_reset_n = 1'b0;
        #1;
        check("t6_async_inst_valid", w_inst_valid, 0);
        check("t6_async_req_valid", w_req_valid, 0);
        repeat (2) @(posedge clk);
        #2 w_reset_n = 1'b1;
        w_pcs.delete(); w_data.delete(); w_errs.delete();
        w_cycles(6);
        if (w_pcs.size() >= 1) check("t6_restart_pc", w_pcs[0], WRAP_PC);
        else check("t6_restart_count", w_pcs.size(), 1);

        // Randomised traffic: ready/latency jitter, faults, redirects (some misaligned)
        do_reset(); lat_min = 1; lat_max = 4; rand_err = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0;
            else t = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0, t);
        end
        check("rand_liveness", cons_pc.size() > 300, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
